l5_ram_arbiter: RTL
===================

# l5_ram_arbiter

Two-port round-robin arbiter and sequencer for the `L5_RAM_256X32` single-port RAM. It lets two independent requesters (port 0, port 1) share the RAM. It drives the RAM's `a`/`cs`/`oe`/`we`/`di` pins from registered outputs and routes returned read data back to the requester that issued the read. Throughput is one access per clock, with fair alternation under contention.

## Interface
Parameters:
- `AW`, 8, RAM address width (256 words)
- `DW`, 32, RAM data width

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1: single system clock; all flops on its rising edge
- `rst_n` in 1: asynchronous active-low reset
- `req0`, `req1` in 1: access request, held until granted
- `we0`, `we1` in 1: 1 = write, 0 = read; qualified by `reqN`
- `addr0`, `addr1` in AW: word address
- `wdata0`, `wdata1` in DW: write data
- `gnt0`, `gnt1` out 1: combinational grant; a transfer occurs at the edge where `reqN && gntN`
- `rvalid0`, `rvalid1` out 1: one-cycle pulse, read data for port N present on `rdata`
- `rdata` out DW: read data shared by both ports; `ram_dout` passthrough
- `ram_a` out AW: RAM address
- `ram_cs`, `ram_oe`, `ram_we` out 1: RAM controls
- `ram_di` out DW: RAM write data
- `ram_dout` in DW: RAM read data

## Operation
- Arbitration each cycle:
  - only one `reqN` high: grant it.
  - both high: grant the port not served by the last transfer (`last_id`).
  - neither high: no grant.
- At most one `gntN` is high at a time. `gntN` is never high while `reqN` is low.
- Issue stage, registered on a transfer edge:
  - `ram_a` ← addr
  - `ram_di` ← wdata
  - `ram_cs` ← 1
  - `ram_we` ← we
  - `ram_oe` ← !we
  - `last_id` ← granted port
- Edge with no transfer: `ram_cs`, `ram_we` and `ram_oe` go to 0. `ram_a` and `ram_di` hold.
- RAM contract:
  - writes on the rising edge when `cs && we`.
  - read data is valid on `ram_dout` in the cycle after the one in which `cs && oe` is presented.
- Read-return pipeline: a 2-deep shift of {valid, id}.
  - Stage 1 loads {transfer && !we, granted id} on the transfer edge.
  - Stage 2 follows stage 1 on the next edge.
  - `rvalidN` = stage-2 valid && id == N.
- Writes produce no response. The write is complete when the RAM samples it, in the cycle after the grant.
- Ordering: accesses reach the RAM in grant order. A read granted after a write to the same address returns the new data.

## Timing
- Request in cycle N with grant in N → RAM sees the command in N+1.
- For a read, `rvalidN` and `rdata` are valid in N+2. Read latency is 2 cycles from the grant edge.
- Back-to-back grants on consecutive cycles are legal. Up to 2 reads are in flight; their `rvalid` pulses appear in grant order, one per cycle.
- Reset values (also during the asynchronous reset):
  - `ram_cs`, `ram_oe`, `ram_we` = 0
  - `ram_a` = 0, `ram_di` = 0
  - both pipeline stages invalid, `rvalid0` = `rvalid1` = 0
  - `last_id` = 1, so port 0 wins the first tie
- Reset mid-operation discards in-flight reads: no `rvalid` is issued for them after reset release.
- Continuous contention strictly alternates ports: 0,1,0,1…
- A port requesting alone is granted every cycle with no penalty. `last_id` still updates.
- Address wrap: `addr` is used verbatim. No increment logic inside the block.

## Structure
- Shared package `l5_ram_pkg`:
  - `L5_AW` = 8, `L5_DW` = 32
  - `port_id_t` (1 bit)
  - a struct `ram_cmd_t` {we, addr, wdata}
- Sub-module `l5_rr_arb2`: a combinational 2-way round-robin picker. Inputs are `req[1:0]` and `last_id`; outputs are one-hot `gnt[1:0]` and the granted id.
- The top level holds the issue registers, `last_id` and the 2-stage return pipeline.

## Test plan
- Port 0 alone writes 0xDEADBEEF to 0x10, then reads 0x10. Required response:
  - `gnt0` on each request cycle.
  - `ram_cs`/`ram_we` = 1/1 in the cycle after the write grant.
  - `rvalid0` = 1 with `rdata` = 0xDEADBEEF 2 cycles after the read grant.
  - `rvalid1` stays 0.
- Both ports hold read requests for 6 cycles (port 0 at 0x01, port 1 at 0x02). Required response:
  - grants go 0,1,0,1,0,1.
  - `rvalid` pulses alternate with the matching data, each 2 cycles behind its grant.
- Port 1 writes 0x12345678 to 0xFF; on the next cycle port 0 reads 0xFF. Required response: `rvalid0` with 0x12345678, proving ordering and the edge-of-range address.
- Fill the RAM: port 0 writes `$random` to addresses 0..255; then both ports read alternately over 0..255. Every `rvalid` returns the stored value and goes to the requesting port.
- Assert `rst_n` = 0 one cycle after a read grant. Required response:
  - all RAM controls go to 0 immediately.
  - no `rvalid` appears after release.
  - the first tie after reset grants port 0.
- `req0` = `req1` = 0 for 3 cycles. Required response: no grants, `ram_cs` = 0, `ram_a`/`ram_di` unchanged.

Source files
------------

// File: rtl/l5_ram_pkg.sv
// Shared types and constants for the L5_RAM_256X32 two-port arbiter slice.
// Port ids are one bit, so the "other" port of a tie is simply the inverted id.
package l5_ram_pkg;

   localparam int L5_AW = 8;
   localparam int L5_DW = 32;

   typedef logic port_id_t;

   typedef struct packed {
      logic             we;
      logic [L5_AW-1:0] addr;
      logic [L5_DW-1:0] wdata;
   } ram_cmd_t;

   function automatic port_id_t other_port(input port_id_t id);
      return ~id;
   endfunction

endpackage

// File: rtl/l5_rr_arb2.sv
// Combinational 2-way round-robin picker: a lone requester always wins,
// a tie goes to the port that did not own the previous transfer.
module l5_rr_arb2
   import l5_ram_pkg::*;
(
   input  logic [1:0] req,
   input  port_id_t   last_id,
   output logic [1:0] gnt,
   output port_id_t   gnt_id
);

   always_comb begin
      gnt    = 2'b00;
      gnt_id = 1'b0;
      case (req)
         2'b01: begin
            gnt    = 2'b01;
            gnt_id = 1'b0;
         end
         2'b10: begin
            gnt    = 2'b10;
            gnt_id = 1'b1;
         end
         2'b11: begin
            gnt_id = other_port(last_id);
            gnt    = gnt_id ? 2'b10 : 2'b01;
         end
         default: begin
            gnt    = 2'b00;
            gnt_id = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/l5_ram_arbiter.sv
// Two-port round-robin sequencer for the L5_RAM_256X32 single-port RAM.
// Registers one command per clock toward the RAM and steers read data back to its requester.
module l5_ram_arbiter
   import l5_ram_pkg::*;
#(
   parameter int AW = L5_AW,
   parameter int DW = L5_DW
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] ram_a,
   output logic          ram_cs,
   output logic          ram_oe,
   output logic          ram_we,
   output logic [DW-1:0] ram_di,
   input  logic [DW-1:0] ram_dout
);

   logic [1:0]    gnt;
   port_id_t      gnt_id;
   port_id_t      last_id;
   logic          transfer;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   logic          s1_valid;
   port_id_t      s1_id;
   logic          s2_valid;
   port_id_t      s2_id;

   l5_rr_arb2 u_arb (
      .req     ({req1, req0}),
      .last_id (last_id),
      .gnt     (gnt),
      .gnt_id  (gnt_id)
   );

   assign gnt0     = gnt[0];
   assign gnt1     = gnt[1];
   assign transfer = |gnt;

   always_comb begin
      sel_we    = we0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
      if (gnt_id) begin
         sel_we    = we1;
         sel_addr  = addr1;
         sel_wdata = wdata1;
      end
   end

   // Address and write data hold on idle edges; only the strobes drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_a   <= '0;
         ram_di  <= '0;
         ram_cs  <= 1'b0;
         ram_we  <= 1'b0;
         ram_oe  <= 1'b0;
         last_id <= 1'b1;
      end else if (transfer) begin
         ram_a   <= sel_addr;
         ram_di  <= sel_wdata;
         ram_cs  <= 1'b1;
         ram_we  <= sel_we;
         ram_oe  <= !sel_we;
         last_id <= gnt_id;
      end else begin
         ram_cs  <= 1'b0;
         ram_we  <= 1'b0;
         ram_oe  <= 1'b0;
      end
   end

   // Stage 1 lines up with the RAM command, stage 2 with the RAM's read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_id    <= 1'b0;
         s2_valid <= 1'b0;
         s2_id    <= 1'b0;
      end else begin
         s1_valid <= transfer && !sel_we;
         s1_id    <= gnt_id;
         s2_valid <= s1_valid;
         s2_id    <= s1_id;
      end
   end

   assign rvalid0 = s2_valid && (s2_id == 1'b0);
   assign rvalid1 = s2_valid && (s2_id == 1'b1);
   assign rdata   = ram_dout;

endmodule
